// File: rtl/e_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : e_muldiv_unit
//  Description : E-stage multiply/divide unit. Runs MULT/MULTU/DIV/DIVU over a
//                fixed latency and then updates HI/LO. Also services MTHI/MTLO
//                and exposes HI/LO for MFHI/MFLO.
//  Revision    : 1.0 - initial release
// ============================================================================
module e_muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hi_write,
    input  logic        lo_write,
    output logic        busy,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [5:0] c_mult_cnt = 6'(MULT_CYCLES);
    localparam logic [5:0] c_div_cnt  = 6'(DIV_CYCLES);

    logic [5:0]  r_cnt;
    logic [1:0]  r_op;
    logic [31:0] r_rs;
    logic [31:0] r_rt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_launch;
    logic        w_is_div;
    logic        w_signed;
    logic        w_div_zero;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [63:0] w_prod;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign busy   = (r_cnt != 6'd0);
    assign hi_out = r_hi;
    assign lo_out = r_lo;

    // Reserved opcodes (bit 2 set) never launch; neither does a start while busy.
    assign w_launch = md_start & ~busy & ~md_op[2];

    // Result datapath, driven only by the latched operands. Division works on
    // magnitudes so the -2^31 / -1 corner falls out naturally as 0x80000000.
    always_comb begin
        w_is_div   = r_op[1];
        w_signed   = ~r_op[0];
        w_div_zero = (r_rt == 32'd0);
        w_a_neg    = w_signed & r_rs[31];
        w_b_neg    = w_signed & r_rt[31];
        w_a_mag    = w_a_neg ? (32'd0 - r_rs) : r_rs;
        w_b_mag    = w_b_neg ? (32'd0 - r_rt) : r_rt;
        // Substitute a harmless divisor on /0; the result is discarded anyway.
        w_b_safe   = w_div_zero ? 32'd1 : w_b_mag;
        w_q_mag    = w_a_mag / w_b_safe;
        w_r_mag    = w_a_mag % w_b_safe;
        if (w_signed)
            w_prod = $signed({{32{r_rs[31]}}, r_rs}) * $signed({{32{r_rt[31]}}, r_rt});
        else
            w_prod = {32'd0, r_rs} * {32'd0, r_rt};
        if (w_is_div) begin
            w_res_lo = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
            w_res_hi = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
        end else begin
            w_res_lo = w_prod[31:0];
            w_res_hi = w_prod[63:32];
        end
    end

    // Launch/countdown/retire plus MTHI/MTLO; a start request always beats a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 6'd0;
            r_op  <= 2'd0;
            r_rs  <= 32'd0;
            r_rt  <= 32'd0;
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
        end else if (w_launch) begin
            r_op  <= md_op[1:0];
            r_rs  <= rs_val;
            r_rt  <= rt_val;
            r_cnt <= md_op[1] ? c_div_cnt : c_mult_cnt;
        end else if (busy) begin
            r_cnt <= r_cnt - 6'd1;
            if (r_cnt == 6'd1 && !(w_is_div && w_div_zero)) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end else if (!md_start) begin
            if (hi_write)
                r_hi <= rs_val;
            if (lo_write)
                r_lo <= rs_val;
        end
    end

endmodule
`default_nettype wire
